// File: rtl/hea_func_pack.sv
// Shared AES helpers for the HEA datapath: GF(2^8) byte arithmetic, state/column
// types and the FSM encoding used by the iterative MixColumns engine.
package hea_func_pack;

  localparam int AES_NCOLS = 4;

  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_RUN,
    MC_DONE
  } mc_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1, staying within 8 bits.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Constant multiply for the MixColumns / InvMixColumns matrix entries.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      4'h1:    gmul = b;
      4'h2:    gmul = x2;
      4'h3:    gmul = x2 ^ b;
      4'h9:    gmul = x8 ^ b;
      4'hB:    gmul = x8 ^ x2 ^ b;
      4'hD:    gmul = x8 ^ x4 ^ b;
      4'hE:    gmul = x8 ^ x4 ^ x2;
      default: gmul = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
// Byte 0 of the column sits in col_in[31:24].
module mix_column_word
  import hea_func_pack::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [3:0] k0, k1, k2, k3;

  // One circulant row: k0 multiplies the byte on the diagonal.
  function automatic logic [7:0] mix_row(input logic [7:0] d0, input logic [7:0] d1,
                                         input logic [7:0] d2, input logic [7:0] d3,
                                         input logic [3:0] c0, input logic [3:0] c1,
                                         input logic [3:0] c2, input logic [3:0] c3);
    return gmul(d0, c0) ^ gmul(d1, c1) ^ gmul(d2, c2) ^ gmul(d3, c3);
  endfunction

  always_comb begin
    {a0, a1, a2, a3} = col_in;
    if (inv) {k0, k1, k2, k3} = {4'hE, 4'hB, 4'hD, 4'h9};
    else     {k0, k1, k2, k3} = {4'h2, 4'h3, 4'h1, 4'h1};
    col_out = {mix_row(a0, a1, a2, a3, k0, k1, k2, k3),
               mix_row(a1, a2, a3, a0, k0, k1, k2, k3),
               mix_row(a2, a3, a0, a1, k0, k1, k2, k3),
               mix_row(a3, a0, a1, a2, k0, k1, k2, k3)};
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine: COLS_PER_CYCLE columns per cycle,
// valid/ready on both sides, back-to-back blocks via DONE -> RUN.
module mix_columns_iter
  import hea_func_pack::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NCOLS   = AES_NCOLS;
  localparam int NGROUPS = NCOLS / COLS_PER_CYCLE;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGROUPS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e                state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NCOLS-1:0][31:0]   src_q, src_d;
  logic [NCOLS-1:0][31:0]   res_q, res_d;
  logic                     inv_q, inv_d;
  logic                     accept;
  logic                     last_grp;

  aes_col_t   grp_in  [COLS_PER_CYCLE];
  aes_col_t   grp_out [COLS_PER_CYCLE];
  logic [1:0] grp_idx [COLS_PER_CYCLE];

  assign accept   = in_valid & in_ready;
  assign last_grp = (cnt_q == LAST_GRP);
  assign out_data = res_q;

  // Column mux: packed index NCOLS-1-c holds column c (column 0 is the MSW).
  always_comb begin
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      grp_idx[j] = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
      grp_in[j]  = src_q[2'(NCOLS - 1) - grp_idx[j]];
    end
  end

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    mix_column_word u_mcw (
      .col_in  (grp_in[j]),
      .inv     (inv_q),
      .col_out (grp_out[j])
    );
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      MC_IDLE: if (accept) state_d = MC_RUN;
      MC_RUN:  if (last_grp) state_d = MC_DONE;
      MC_DONE: begin
        if (accept)         state_d = MC_RUN;
        else if (out_ready) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  // FSM outputs; in_ready sees out_ready only while a result is waiting.
  always_comb begin
    in_ready  = (state_q == MC_IDLE) || ((state_q == MC_DONE) && out_ready);
    out_valid = (state_q == MC_DONE);
  end

  always_comb begin
    src_d = src_q;
    inv_d = inv_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (accept) begin
      src_d = in_data;
      inv_d = in_inv;
      cnt_d = '0;
    end else if (state_q == MC_RUN) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        res_d[2'(NCOLS - 1) - grp_idx[j]] = grp_out[j];
      end
      cnt_d = last_grp ? '0 : cnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // NOTE: source and mode regs are always loaded on accept before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    src_q <= src_d;
    inv_q <= inv_d;
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench: drives mix_columns_iter with COLS_PER_CYCLE = 1, 2 and 4 in turn
// against a GF(2^8) matrix-multiply model and FIPS-197 literal vectors.
module tb_mix_columns_iter;
  import hea_func_pack::*;

  localparam int NDUT = 3;

  localparam aes_state_t V_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam aes_state_t V_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam aes_state_t C_IN  = 128'hdb135345c6c6c6c6db135345c6c6c6c6;
  localparam aes_state_t C_OUT = 128'h8e4da1bcc6c6c6c68e4da1bcc6c6c6c6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [NDUT];
  logic       in_ready  [NDUT];
  aes_state_t in_data   [NDUT];
  logic       in_inv    [NDUT];
  logic       out_valid [NDUT];
  logic       out_ready [NDUT];
  aes_state_t out_data  [NDUT];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cur      = 0;
  bit         rand_ready = 1'b0;
  aes_state_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  // ---------------- reference model: plain polynomial arithmetic ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic aes_col_t model_col(input aes_col_t col, input bit inv);
    logic [7:0] row0 [4];
    logic [7:0] a [4];
    logic [7:0] b;
    aes_col_t   r = '0;
    if (inv) row0 = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      b = '0;
      for (int j = 0; j < 4; j++) b = b ^ gf_mul(row0[(j - i + 4) % 4], a[j]);
      r[31-8*i -: 8] = b;
    end
    return r;
  endfunction

  function automatic aes_state_t model_state(input aes_state_t s, input bit inv);
    aes_state_t r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(s[127-32*c -: 32], inv);
    return r;
  endfunction

  function automatic aes_state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- single compare process on the output handshake ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid[cur] && out_ready[cur]) begin
      if (exp_q.size() == 0)
        check($sformatf("spurious_out_c%0d", 1 << cur), 128'(out_valid[cur]), 128'd0);
      else
        check($sformatf("out_data_c%0d", 1 << cur), out_data[cur], exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready[cur] = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input aes_state_t d, input bit inv,
                      input aes_state_t exp, output int waited);
    waited = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_inv[k]   = inv;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready[k] && waited < 200);
    if (!in_ready[k]) check($sformatf("accept_timeout_c%0d", 1 << k), 128'd0, 128'd1);
    else exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_data[k]  = rand_state();
    in_inv[k]   = $urandom_range(0, 1) != 0;
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain_c%0d", 1 << k), 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         w, lat, t;
    aes_state_t a, b, ea;

    for (int k = 0; k < NDUT; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_inv[k] = 1'b0; out_ready[k] = 1'b1;
    end
    rst_n = 1'b0;

    // Pin the model itself to hand-checked vectors.
    check("model_fips_fwd", model_state(V_IN, 1'b0), V_OUT);
    check("model_fips_inv", model_state(V_OUT, 1'b1), V_IN);
    check("model_col_db", 128'(model_col(32'hdb135345, 1'b0)), 128'h8e4da1bc);
    check("model_col_c6", 128'(model_col(32'hc6c6c6c6, 1'b1)), 128'hc6c6c6c6);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_out_valid_c%0d", 1 << k), 128'(out_valid[k]), 128'd0);
      check($sformatf("rst_out_data_c%0d", 1 << k), out_data[k], 128'd0);
      check($sformatf("rst_in_ready_c%0d", 1 << k), 128'(in_ready[k]), 128'd1);
    end
    @(posedge clk);
    #1;

    for (int k = 0; k < NDUT; k++) begin
      cur = k;

      // Zero state plus exact latency of 4/C edges after the accept edge.
      send(k, '0, 1'b0, '0, w);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!out_valid[k] && lat < 20);
      check($sformatf("latency_c%0d", 1 << k), 128'(lat), 128'(4 >> k));
      drain(k);

      // Literal vectors, forward and inverse.
      send(k, V_IN, 1'b0, V_OUT, w);  drain(k);
      send(k, V_OUT, 1'b1, V_IN, w);  drain(k);
      send(k, C_IN, 1'b0, C_OUT, w);  drain(k);
      send(k, C_OUT, 1'b1, C_IN, w);  drain(k);

      // Backpressure in DONE, then release together with a new block.
      out_ready[k] = 1'b0;
      a  = rand_state();
      ea = model_state(a, 1'b0);
      send(k, a, 1'b0, ea, w);
      t = 0;
      while (!out_valid[k] && t < 20) begin
        @(negedge clk);
        t++;
      end
      repeat (5) begin
        @(negedge clk);
        check($sformatf("bp_out_valid_c%0d", 1 << k), 128'(out_valid[k]), 128'd1);
        check($sformatf("bp_out_data_c%0d", 1 << k), out_data[k], ea);
        check($sformatf("bp_in_ready_c%0d", 1 << k), 128'(in_ready[k]), 128'd0);
      end
      @(posedge clk);
      #1;
      out_ready[k] = 1'b1;
      b = rand_state();
      send(k, b, 1'b1, model_state(b, 1'b1), w);
      check($sformatf("bp_same_cycle_accept_c%0d", 1 << k), 128'(w), 128'd1);
      drain(k);

      // Abort mid-RUN (only meaningful when RUN spans several cycles).
      if (k == 0) begin
        send(k, V_IN, 1'b0, V_OUT, w);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
          @(negedge clk);
          check("abort_out_valid", 128'(out_valid[k]), 128'd0);
          check("abort_in_ready", 128'(in_ready[k]), 128'd1);
        end
        @(posedge clk);
        #1;
        send(k, V_IN, 1'b0, V_OUT, w);
        drain(k);
      end

      // Randomized traffic with input gaps and output stalls, plus round-trips.
      rand_ready = 1'b1;
      for (int i = 0; i < 340; i++) begin
        bit inv;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        a   = rand_state();
        inv = $urandom_range(0, 1) != 0;
        ea  = model_state(a, inv);
        send(k, a, inv, ea, w);
        if ($urandom_range(0, 3) == 0) send(k, ea, !inv, a, w);
      end
      drain(k);
      rand_ready = 1'b0;
      @(posedge clk);
      #2 out_ready[k] = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
